// File: rtl/pipe_arb_pkg.sv
// Shared types for pipe_mem_arbiter: FSM states, grant-source encoding and default widths.
// Optional perf counters (pipe_arb_perf) are enabled with PIPE_ARB_PERF_EN.
package pipe_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } src_e;

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// Bundle of the IF port, DM port, stall and memory-side handshake signals of pipe_mem_arbiter.
// slave = arbiter side, master = CPU pipeline / memory environment side.
interface pipe_mem_arbiter_if
  import pipe_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;

  logic              stall_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o, stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o, stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/pipe_arb_perf.sv
// Saturating performance counters for pipe_mem_arbiter; only instantiated when
// PIPE_ARB_PERF_EN is defined.
module pipe_arb_perf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall,
  input  logic        if_ack,
  input  logic        dm_ack,
  output logic [31:0] perf_stall_cyc_o,
  output logic [31:0] perf_if_cnt_o,
  output logic [31:0] perf_dm_cnt_o
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_cyc_o <= '0;
      perf_if_cnt_o    <= '0;
      perf_dm_cnt_o    <= '0;
    end else begin
      perf_stall_cyc_o <= sat_inc(perf_stall_cyc_o, stall);
      perf_if_cnt_o    <= sat_inc(perf_if_cnt_o, if_ack);
      perf_dm_cnt_o    <= sat_inc(perf_dm_cnt_o, dm_ack);
    end
  end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates a single-port unified memory between the IF and MEM-stage ports (DM has priority)
// and stalls the pipeline while an accepted request is outstanding. PIPE_ARB_PERF_EN adds perf counters.
module pipe_mem_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_mem_arbiter_if.slave   bus
`ifdef PIPE_ARB_PERF_EN
  ,
  output logic [31:0]         perf_stall_cyc_o,
  output logic [31:0]         perf_if_cnt_o,
  output logic [31:0]         perf_dm_cnt_o
`endif
);

  state_e            state, state_nxt;
  src_e              src_p0;
  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] if_rdata_p1;
  logic [DATA_W-1:0] dm_rdata_p1;
  logic              grant_dm, grant_if, mem_done;

  assign grant_dm = (state == IDLE) && bus.dm_req_i;
  assign grant_if = (state == IDLE) && !bus.dm_req_i && bus.if_req_i;
  assign mem_done = ((state == GNT_IF) || (state == GNT_DM)) && bus.mem_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.dm_req_i)      state_nxt = GNT_DM;
        else if (bus.if_req_i) state_nxt = GNT_IF;
      end
      GNT_IF, GNT_DM: if (bus.mem_ack_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req_o = (state == GNT_IF) || (state == GNT_DM);
    bus.if_ack_o  = (state == DONE) && (src_p0 == SRC_IF);
    bus.dm_ack_o  = (state == DONE) && (src_p0 == SRC_DM);
  end

  // Stage p0: request latched at grant, held on the memory bus for the whole access
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_p0   <= SRC_IF;
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
    end else if (grant_dm) begin
      src_p0   <= SRC_DM;
      we_p0    <= bus.dm_we_i;
      addr_p0  <= bus.dm_addr_i;
      wdata_p0 <= bus.dm_wdata_i;
    end else if (grant_if) begin
      src_p0   <= SRC_IF;
      we_p0    <= 1'b0;
      addr_p0  <= bus.if_addr_i;
      wdata_p0 <= '0;
    end
  end

  // Stage p1: read data captured on mem_ack_i; writes leave the port's rdata untouched
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_rdata_p1 <= '0;
      dm_rdata_p1 <= '0;
    end else if (mem_done && !we_p0) begin
      if (src_p0 == SRC_IF) if_rdata_p1 <= bus.mem_rdata_i;
      else                  dm_rdata_p1 <= bus.mem_rdata_i;
    end
  end

  assign bus.mem_we_o    = we_p0;
  assign bus.mem_addr_o  = addr_p0;
  assign bus.mem_wdata_o = wdata_p0;
  assign bus.if_rdata_o  = if_rdata_p1;
  assign bus.dm_rdata_o  = dm_rdata_p1;

  // Drops in the ack cycle so the pipeline advances on the edge that closes it
  assign bus.stall_o = !rst_i && ((bus.if_req_i && !bus.if_ack_o) ||
                                  (bus.dm_req_i && !bus.dm_ack_o));

`ifdef PIPE_ARB_PERF_EN
  pipe_arb_perf u_perf (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stall            (bus.stall_o),
    .if_ack           (bus.if_ack_o),
    .dm_ack           (bus.dm_ack_o),
    .perf_stall_cyc_o (perf_stall_cyc_o),
    .perf_if_cnt_o    (perf_if_cnt_o),
    .perf_dm_cnt_o    (perf_dm_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed, table-driven bench for pipe_mem_arbiter with a variable-latency memory responder.
// Perf counter checks are compiled in when PIPE_ARB_PERF_EN is defined.
module tb_pipe_mem_arbiter;

  logic clk;
  logic rst_i;

  pipe_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef PIPE_ARB_PERF_EN
  logic [31:0] perf_stall_cyc_o, perf_if_cnt_o, perf_dm_cnt_o;
`endif

  pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef PIPE_ARB_PERF_EN
    ,
    .perf_stall_cyc_o (perf_stall_cyc_o),
    .perf_if_cnt_o    (perf_if_cnt_o),
    .perf_dm_cnt_o    (perf_dm_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // memory model controls (written only by the main process)
  logic        mem_en    = 1'b0;
  int          mem_delay = 1;
  logic [31:0] mem_val   = '0;
  logic        late_ack  = 1'b0;

  // memory responder: acks mem_delay cycles after mem_req_o first seen high
  initial begin
    int reqcnt;
    reqcnt          = 0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_ack_i = 1'b0;
      if (mem_en) begin
        if (bus.mem_req_o) begin
          reqcnt++;
          if (reqcnt == mem_delay + 1) begin
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = mem_val;
          end
        end else begin
          reqcnt = 0;
        end
      end else begin
        reqcnt = 0;
        if (late_ack) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = mem_val;
        end
      end
    end
  end

  int stall_total = 0;
  always @(posedge clk) if (bus.stall_o) stall_total <= stall_total + 1;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] mval;
    logic        chg;
    logic        drop;
    int          ack_cyc;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   cyc;
    logic acked;
    logic req_now;
    logic port_ack, other_ack;
    logic [31:0] port_rd;
    mem_delay = v.dly;
    mem_val   = v.mval;
    if (v.is_dm) begin
      bus.dm_we_i    = v.we;
      bus.dm_addr_i  = v.addr;
      bus.dm_wdata_i = v.wdata;
      bus.dm_req_i   = 1'b1;
    end else begin
      bus.if_addr_i  = v.addr;
      bus.if_req_i   = 1'b1;
    end
    req_now = 1'b1;
    cyc     = 0;
    acked   = 1'b0;
    while (!acked && cyc < 40) begin
      tick();
      cyc++;
      port_ack  = v.is_dm ? bus.dm_ack_o   : bus.if_ack_o;
      other_ack = v.is_dm ? bus.if_ack_o   : bus.dm_ack_o;
      port_rd   = v.is_dm ? bus.dm_rdata_o : bus.if_rdata_o;
      check($sformatf("v%0d_other_ack_c%0d", id, cyc), other_ack, 1'b0);
      if (bus.mem_req_o) begin
        check($sformatf("v%0d_mem_addr_c%0d", id, cyc), bus.mem_addr_o, v.addr);
        check($sformatf("v%0d_mem_we_c%0d", id, cyc), bus.mem_we_o, v.we);
        if (v.we) check($sformatf("v%0d_mem_wdata_c%0d", id, cyc), bus.mem_wdata_o, v.wdata);
      end
      if (port_ack) begin
        acked = 1'b1;
        check($sformatf("v%0d_ack_cycle", id), cyc, v.ack_cyc);
        check($sformatf("v%0d_rdata", id), port_rd, v.exp_rd);
        check($sformatf("v%0d_stall_at_ack", id), bus.stall_o, 1'b0);
        check($sformatf("v%0d_mem_req_at_ack", id), bus.mem_req_o, 1'b0);
      end else begin
        check($sformatf("v%0d_stall_c%0d", id, cyc), bus.stall_o, req_now);
      end
      if (cyc == 2 && v.chg) begin
        bus.dm_wdata_i = 32'h0;
        bus.dm_addr_i  = 32'h0;
      end
      if (cyc == 2 && v.drop) begin
        bus.dm_req_i = 1'b0;
        req_now      = 1'b0;
      end
    end
    if (!acked) check($sformatf("v%0d_ack_timeout", id), 32'd0, 32'd1);
    bus.if_req_i = 1'b0;
    bus.dm_req_i = 1'b0;
    tick();
    check($sformatf("v%0d_ack_single", id), v.is_dm ? bus.dm_ack_o : bus.if_ack_o, 1'b0);
    check($sformatf("v%0d_mem_req_gap", id), bus.mem_req_o, 1'b0);
  endtask

  initial begin
    //            dm   we    addr          wdata         dly mval          chg  drop ack exp_rd
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,        1, 32'h2001_0005, 1'b0, 1'b0, 3, 32'h2001_0005};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        1, 32'h1111_2222, 1'b0, 1'b0, 3, 32'h1111_2222};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 2, 32'hBAD0_BAD0, 1'b1, 1'b0, 4, 32'h1111_2222};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        7, 32'h00A0_0093, 1'b0, 1'b0, 9, 32'h00A0_0093};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        3, 32'hCAFE_F00D, 1'b0, 1'b1, 5, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,        1, 32'h1234_5678, 1'b0, 1'b0, 3, 32'h1234_5678};

    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_addr_i  = '0;
    bus.dm_wdata_i = '0;

    // reset state, with a request pending so stall gating is visible
    rst_i = 1'b1;
    tick();
    bus.if_req_i = 1'b1;
    tick();
    check("rst_mem_req", bus.mem_req_o, 1'b0);
    check("rst_mem_we", bus.mem_we_o, 1'b0);
    check("rst_if_ack", bus.if_ack_o, 1'b0);
    check("rst_dm_ack", bus.dm_ack_o, 1'b0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    check("rst_if_rdata", bus.if_rdata_o, 32'h0);
    check("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
    check("rst_stall", bus.stall_o, 1'b0);
    bus.if_req_i = 1'b0;
    rst_i  = 1'b0;
    mem_en = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // simultaneous IF + DM: DM first, gap, then IF
    mem_delay      = 1;
    mem_val        = 32'h0BAD_F00D;
    bus.if_addr_i  = 32'h0000_0030;
    bus.dm_addr_i  = 32'h0000_0010;
    bus.dm_we_i    = 1'b0;
    bus.if_req_i   = 1'b1;
    bus.dm_req_i   = 1'b1;
    tick();
    check("sim_c1_mem_req", bus.mem_req_o, 1'b1);
    check("sim_c1_addr", bus.mem_addr_o, 32'h0000_0010);
    check("sim_c1_stall", bus.stall_o, 1'b1);
    tick();
    check("sim_c2_stall", bus.stall_o, 1'b1);
    tick();
    check("sim_c3_dm_ack", bus.dm_ack_o, 1'b1);
    check("sim_c3_if_ack", bus.if_ack_o, 1'b0);
    check("sim_c3_dm_rdata", bus.dm_rdata_o, 32'h0BAD_F00D);
    check("sim_c3_mem_req", bus.mem_req_o, 1'b0);
    check("sim_c3_stall", bus.stall_o, 1'b1);
    bus.dm_req_i = 1'b0;
    mem_val      = 32'h0000_0013;
    tick();
    check("sim_c4_mem_req", bus.mem_req_o, 1'b0);
    check("sim_c4_dm_ack", bus.dm_ack_o, 1'b0);
    check("sim_c4_stall", bus.stall_o, 1'b1);
    tick();
    check("sim_c5_mem_req", bus.mem_req_o, 1'b1);
    check("sim_c5_addr", bus.mem_addr_o, 32'h0000_0030);
    check("sim_c5_we", bus.mem_we_o, 1'b0);
    tick();
    check("sim_c6_stall", bus.stall_o, 1'b1);
    tick();
    check("sim_c7_if_ack", bus.if_ack_o, 1'b1);
    check("sim_c7_if_rdata", bus.if_rdata_o, 32'h0000_0013);
    check("sim_c7_stall", bus.stall_o, 1'b0);
    bus.if_req_i = 1'b0;
    tick();
    check("sim_c8_if_ack", bus.if_ack_o, 1'b0);

    // reset in GNT_DM followed by a late memory ack
    mem_en        = 1'b0;
    bus.dm_addr_i = 32'h0000_0040;
    bus.dm_we_i   = 1'b0;
    bus.dm_req_i  = 1'b1;
    tick();
    check("rmg_c1_mem_req", bus.mem_req_o, 1'b1);
    rst_i        = 1'b1;
    bus.dm_req_i = 1'b0;
    tick();
    check("rmg_c2_mem_req", bus.mem_req_o, 1'b0);
    check("rmg_c2_dm_ack", bus.dm_ack_o, 1'b0);
    check("rmg_c2_stall", bus.stall_o, 1'b0);
    rst_i    = 1'b0;
    mem_val  = 32'h7777_7777;
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    check("rmg_c3_dm_ack", bus.dm_ack_o, 1'b0);
    tick();
    check("rmg_c4_dm_ack", bus.dm_ack_o, 1'b0);
    check("rmg_c4_mem_req", bus.mem_req_o, 1'b0);
    check("rmg_c4_dm_rdata", bus.dm_rdata_o, 32'h0);
    mem_en = 1'b1;
    run_vec(vecs[0], 10);

`ifdef PIPE_ARB_PERF_EN
    begin
      int base;
      rst_i = 1'b1;
      tick();
      tick();
      base  = stall_total;
      rst_i = 1'b0;
      run_vec(vecs[0], 20);
      run_vec(vecs[1], 21);
      run_vec(vecs[5], 22);
      run_vec(vecs[1], 23);
      run_vec(vecs[0], 24);
      check("perf_if_cnt", perf_if_cnt_o, 32'd3);
      check("perf_dm_cnt", perf_dm_cnt_o, 32'd2);
      check("perf_stall_cyc", perf_stall_cyc_o, 32'd15);
      check("perf_stall_vs_seen", perf_stall_cyc_o, stall_total - base);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
